// File: rtl/uart_pkg.sv
// uart_pkg: arbiter FSM encoding and UART framing constants.
// Shared by the arbiter RTL and by benches that need frame timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_LAUNCH_TIMEOUT = 16;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes plus transmitter control.
// Ports: req_valid/req_data/req_ready, tx_start/tx_data/tx_busy, grant_id/active/err_timeout.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [8*NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_start;
    logic [7:0]                 tx_data;
    logic                       tx_busy;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       active;
    logic                       err_timeout;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active, err_timeout
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: one-hot round-robin pick searched from ptr upward with wrap.
// Ports: req, ptr, en in; gnt (one-hot), idx (encoded) out; all zero when en=0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IW = $clog2(NUM_REQ);

    int   c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ producers.
// Ports: clk, rst_n (async low), bus (slave modport: requester handshakes + tx control).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LAUNCH = LAUNCH;
    localparam logic [1:0] S_WAIT   = WAIT_DONE;

    localparam logic [CW-1:0] CNT_LAST = CW'(LAUNCH_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    logic [1:0]         state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      grant_q;
    logic [NUM_REQ-1:0] win_gnt;
    logic [CW-1:0]      cnt;
    logic [7:0]         data_q;
    logic               start_q;
    logic               active_q;
    logic               err_q;
    logic               arb_en;
    logic               accept;

    // A busy transmitter in IDLE is a stale frame; never grant over it.
    assign arb_en = rst_n && (state == S_IDLE) && !bus.tx_busy;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign accept = |win_gnt;

    assign bus.req_ready   = win_gnt;
    assign bus.tx_start    = start_q;
    assign bus.tx_data     = data_q;
    assign bus.grant_id    = grant_q;
    assign bus.active      = active_q;
    assign bus.err_timeout = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            cnt      <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_q   <= bus.req_data[{win_idx, 3'b000} +: 8];
                        grant_q  <= win_idx;
                        rr_ptr   <= (win_idx == IDX_LAST) ? '0
                                  : win_idx + IW'(1);
                        start_q  <= 1'b1;
                        active_q <= 1'b1;
                        cnt      <= '0;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt <= cnt + CW'(1);
                    if (bus.tx_busy) begin
                        start_q <= 1'b0;
                        state   <= S_WAIT;
                    end else if (cnt == CNT_LAST) begin
                        // Transmitter never acknowledged: drop the byte.
                        start_q  <= 1'b0;
                        active_q <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!bus.tx_busy) begin
                        active_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + random checks of the arbiter against a pointer-based model.
// Includes a behavioural clk/2 transmitter that frames bytes (start, data LSB-first, parity, stop).
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) ifc ();

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .LAUNCH_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int nchk  = 0;
    int nfail = 0;
    int mptr  = 0;

    logic        force_busy = 1'b0;
    logic        mute       = 1'b0;
    logic        ph         = 1'b0;
    logic        m_busy     = 1'b0;
    int          m_left     = 0;
    logic [10:0] m_frame    = '0;
    logic [10:0] cap        = '0;

    assign ifc.tx_busy = m_busy | force_busy;

    // Transmitter model: acts on every other clk edge (clk_uart) and
    // is not affected by the arbiter reset.
    always @(posedge clk) begin
        ph <= ~ph;
        if (ph) begin
            if (m_busy) begin
                cap     <= {m_frame[0], cap[10:1]};
                m_frame <= {1'b0, m_frame[10:1]};
                m_left  <= m_left - 1;
                if (m_left == 1) m_busy <= 1'b0;
            end else if (ifc.tx_start && !mute) begin
                m_busy  <= 1'b1;
                m_left  <= FRAME_BITS;
                m_frame <= {1'b1, ^ifc.tx_data, ifc.tx_data, 1'b0};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Caller sits between a negedge and the next posedge with DUT idle.
    task automatic do_frame(input logic [N-1:0] v, input logic [8*N-1:0] d,
                            input bit keep, input bit expect_to);
        int e, n_st, n_err, guard;
        logic [7:0] b;
        bit extra;
        ifc.req_valid = v;
        ifc.req_data  = d;
        e = pick(v, mptr);
        b = d[8*e +: 8];
        #1;
        chk("ready", ifc.req_ready, 32'd1 << e);
        @(posedge clk); #1;
        chk("grant_id", ifc.grant_id, e);
        chk("tx_data", ifc.tx_data, b);
        chk("tx_start_rise", ifc.tx_start, 1);
        chk("active_rise", ifc.active, 1);
        mptr = (e + 1) % N;
        @(negedge clk);
        if (!keep) ifc.req_valid = '0;
        #1;
        extra = 0;
        if (expect_to) begin
            n_st = 0;
            n_err = 0;
            for (int k = 0; k < 30; k++) begin
                if (ifc.tx_start) n_st++;
                if (ifc.err_timeout) n_err++;
                @(negedge clk); #1;
            end
            chk("to_start_len", n_st, TO);
            chk("to_err_pulses", n_err, 1);
            chk("to_active", ifc.active, 0);
        end else begin
            guard = 0;
            while (!ifc.tx_busy && guard < 10) begin
                if (ifc.req_ready !== '0) extra = 1;
                @(negedge clk); #1;
                guard++;
            end
            chk("busy_rise", ifc.tx_busy, 1);
            chk("start_held", ifc.tx_start, 1);
            guard = 0;
            while (ifc.tx_busy && guard < 60) begin
                if (ifc.req_ready !== '0) extra = 1;
                @(negedge clk); #1;
                guard++;
            end
            chk("busy_fall", ifc.tx_busy, 0);
            chk("active_hold", ifc.active, 1);
            chk("serial", cap, {1'b1, ^b, b, 1'b0});
            @(negedge clk); #1;
            chk("active_fall", ifc.active, 0);
            chk("no_extra_ready", extra, 0);
        end
    endtask

    initial begin
        logic [8*N-1:0] rd;
        int order [5] = '{0, 1, 2, 3, 0};
        int guard;
        bit extra;

        ifc.req_valid = '0;
        ifc.req_data  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        @(negedge clk);
        ifc.req_valid = '1;
        #1;
        chk("rst_tx_start", ifc.tx_start, 0);
        chk("rst_tx_data", ifc.tx_data, 0);
        chk("rst_grant", ifc.grant_id, 0);
        chk("rst_active", ifc.active, 0);
        chk("rst_err", ifc.err_timeout, 0);
        chk("rst_ready", ifc.req_ready, 0);
        @(negedge clk);
        ifc.req_valid = '0;
        rst_n = 1'b1;
        #1;

        // All requesters valid continuously: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            rd = $urandom;
            do_frame('1, rd, 1, 0);
            chk("rr_order", ifc.grant_id, order[i]);
        end
        ifc.req_valid = '0;

        // Single request with A5 on requester 2
        rd = $urandom;
        rd[23:16] = 8'hA5;
        do_frame(4'b0100, rd, 0, 0);
        chk("a5_grant", ifc.grant_id, 2);
        chk("a5_data", ifc.tx_data, 8'hA5);
        chk("a5_parity", cap[9], 0);

        // Back-to-back: requester 0 stays valid, 3 must win next
        rd = $urandom;
        do_frame(4'b0001, rd, 1, 0);
        rd = $urandom;
        do_frame(4'b1001, rd, 0, 0);
        chk("b2b_winner", ifc.grant_id, 3);

        // Busy forced high in IDLE: no grant, no start
        force_busy = 1'b1;
        ifc.req_valid = 4'b0010;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (ifc.req_ready !== '0 || ifc.tx_start !== 1'b0) extra = 1;
        end
        chk("busy_blocks_grant", extra, 0);
        @(negedge clk);
        force_busy = 1'b0;
        #1;
        chk("busy_release_ready", ifc.req_ready, 4'b0010);
        rd = $urandom;
        do_frame(4'b0010, rd, 0, 0);

        // Launch timeout, then a normal grant afterwards
        mute = 1'b1;
        rd = $urandom;
        do_frame(4'b1000, rd, 0, 1);
        mute = 1'b0;
        rd = $urandom;
        do_frame(4'b1100, rd, 0, 0);

        // Reset in the middle of a frame
        rd = $urandom;
        ifc.req_valid = 4'b0100;
        ifc.req_data  = rd;
        guard = 0;
        while (!ifc.tx_busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        ifc.req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", ifc.tx_start, 0);
        chk("mid_rst_active", ifc.active, 0);
        chk("mid_rst_grant", ifc.grant_id, 0);
        chk("mid_rst_ready", ifc.req_ready, 0);
        chk("mid_rst_busy", ifc.tx_busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mptr = 0;
        #1;
        extra = 0;
        guard = 0;
        while (ifc.tx_busy && guard < 60) begin
            if (ifc.req_ready !== '0 || ifc.tx_start !== 1'b0) extra = 1;
            @(negedge clk); #1;
            guard++;
        end
        chk("stale_no_grant", extra, 0);
        chk("stale_busy_fall", ifc.tx_busy, 0);
        rd = $urandom;
        do_frame(4'b1010, rd, 0, 0);
        chk("post_rst_lowest", ifc.grant_id, 1);

        // Random patterns against the pointer model
        for (int i = 0; i < 24; i++) begin
            rd = $urandom;
            do_frame(N'($urandom_range(1, (1 << N) - 1)), rd,
                     bit'($urandom_range(0, 1)), 0);
        end
        ifc.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter between NUM_REQ byte producers using round-robin arbitration with a valid/ready handshake per requester. Drives the transmitter's start_transmission/data_in and tracks its busy output to sequence one frame at a time. Flags a launch timeout if the transmitter never acknowledges start. Sits between the system-side byte sources and the transmitter, in the clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LAUNCH_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start asserts before aborting

Ports:
clk  input  1  system clock (clk_uart is clk/2, derived synchronously)
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i has a byte
req_data  input  8*NUM_REQ  byte of requester i at [8*i+7:8*i]
req_ready  output  NUM_REQ  one-hot accept; byte i is taken on the edge where valid[i]&ready[i]
tx_start  output  1  to transmitter start_transmission
tx_data  output  8  to transmitter data_in, registered, stable while tx_start or tx_busy is high
tx_busy  input  1  from transmitter busy
grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current frame
active  output  1  high from accept until frame completes or aborts
err_timeout  output  1  one-cycle pulse on launch abort

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_start=0, tx_data=0, grant_id=0, active=0, err_timeout=0, rr pointer=0, timeout counter=0. req_ready evaluates to all zeros while in reset.
- tx_busy is treated as synchronous to clk; no synchronizer.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - req_ready is combinational: the one-hot winner among req_valid, searched from the rr pointer upward with wrap, and only when tx_busy==0. Otherwise all zeros.
  - On an accept edge: tx_data<=winning byte, grant_id<=winner, rr pointer<=(winner+1) mod NUM_REQ, tx_start<=1, active<=1, counter<=0, go to LAUNCH.
  - If tx_busy==1 in IDLE (stale frame, e.g. after reset mid-frame), no grant is given.
- LAUNCH:
  - Hold tx_start=1 and increment the counter each cycle.
  - If tx_busy==1: tx_start<=0, go to WAIT_DONE.
  - Else if counter==LAUNCH_TIMEOUT-1: tx_start<=0, active<=0, err_timeout<=1 for one cycle, go to IDLE. The byte is dropped and not retried. The rr pointer keeps its advanced value.
- WAIT_DONE:
  - Wait for tx_busy==0, then active<=0 and go to IDLE. The next grant is possible the following cycle.
- Latency: valid in IDLE with tx_busy low -> ready in the same cycle -> tx_start high on the next cycle.
- Throughput: one frame per transmitter frame time plus at most 2 clk.
- Simultaneous requests: round-robin from the pointer, so no requester waits more than NUM_REQ-1 frames while it stays valid.
- req_valid deasserting while not accepted is legal and has no effect.
- req_data is only sampled on the accept edge.
- tx_start never asserts while tx_busy is high in IDLE.
- tx_start is held for at least 2 clk, so the clk/2 transmitter always samples it.
- Reset mid-frame: outputs return to reset values immediately. No new grant until tx_busy is observed low.
- Counter width: $clog2(LAUNCH_TIMEOUT+1).

Decomposition:
- Shared package uart_pkg: state encoding enum (IDLE/LAUNCH/WAIT_DONE), default LAUNCH_TIMEOUT, and the UART frame length constant (11 bits: start, 8 data, parity, stop) for bench timing.
- One natural sub-module: rr_arbiter, parameterized NUM_REQ. Inputs are the request vector, the pointer and an enable; output is the one-hot grant plus the encoded index. The FSM and datapath stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 -> req_ready=4'b0100 for one cycle; grant_id=2; tx_data=8'hA5; tx_start high until tx_busy rises; active falls one cycle after tx_busy falls; serial line shows 8'hA5 LSB-first with parity 0.
- All four requesters valid continuously from reset -> grants in order 0,1,2,3,0. Exactly one ready pulse per frame; no overlap between frames.
- Requester 1 valid and tx_busy forced high in IDLE -> req_ready stays 0. It asserts 4'b0010 in the first cycle tx_busy is low.
- tx_busy tied low with LAUNCH_TIMEOUT=16 -> tx_start high for exactly 16 cycles; err_timeout pulses once; state returns to IDLE; the next request is granted afterwards.
- rst_n pulsed low mid-data-bits -> tx_start, active and grant_id read 0 asynchronously. No grant until the transmitter's busy drops. The first post-reset grant goes to the lowest valid index (pointer=0).
- Back-to-back: requester 0 re-asserts valid the cycle after its accept while requester 3 is also valid -> requester 3 wins the next frame (pointer=1 scans 1,2,3).
